// File: rtl/motor_pkg.sv
// Shared types for the dual H-bridge driver: per-channel state encoding,
// decoded drive command and duty-select codes.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_COAST = 2'b00,
        ST_FWD   = 2'b01,
        ST_BWD   = 2'b10,
        ST_DEAD  = 2'b11
    } ch_state_t;

    typedef enum logic [1:0] {
        CMD_COAST = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_BWD   = 2'b10
    } cmd_t;

    localparam logic [1:0] DSEL_0 = 2'b00;
    localparam logic [1:0] DSEL_1 = 2'b01;
    localparam logic [1:0] DSEL_2 = 2'b10;
    localparam logic [1:0] DSEL_3 = 2'b11;

    // FWD and BWD together is not a legal drive request; it degrades to coast.
    function automatic cmd_t decode_cmd(input logic fwd, input logic bwd);
        case ({fwd, bwd})
            2'b10:   return CMD_FWD;
            2'b01:   return CMD_BWD;
            default: return CMD_COAST;
        endcase
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: direction FSM with reversal dead-time, per-period
// duty threshold latch and PWM enable compare against the shared counter.
module motor_channel
    import motor_pkg::*;
#(
    parameter int              TH_W     = 17,
    parameter int              DEADTIME = 50_000,
    parameter logic [TH_W-1:0] TH0      = '0,
    parameter logic [TH_W-1:0] TH1      = '0,
    parameter logic [TH_W-1:0] TH2      = '0,
    parameter logic [TH_W-1:0] TH3      = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fwd,
    input  logic            bwd,
    input  logic [1:0]      duty_sel,
    input  logic [TH_W-1:0] cnt,
    input  logic            wrap,
    output logic            in_fwd,
    output logic            in_bwd,
    output logic            en,
    output logic            fault
);

    localparam int           DW        = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME - 1);

    cmd_t            cmd;
    logic            illegal;
    logic            illegal_q;
    ch_state_t       state_q;
    ch_state_t       state_d;
    logic [DW-1:0]   dcnt_q;
    logic [DW-1:0]   dcnt_d;
    logic [TH_W-1:0] thr_q;
    logic [TH_W-1:0] th_sel;

    assign cmd     = decode_cmd(fwd, bwd);
    assign illegal = fwd & bwd;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_COAST: begin
                if (cmd == CMD_FWD) begin
                    state_d = ST_FWD;
                end else if (cmd == CMD_BWD) begin
                    state_d = ST_BWD;
                end
            end
            ST_FWD: begin
                if (cmd == CMD_COAST) begin
                    state_d = ST_COAST;
                end else if (cmd == CMD_BWD) begin
                    state_d = ST_DEAD;
                    dcnt_d  = DEAD_LOAD;
                end
            end
            ST_BWD: begin
                if (cmd == CMD_COAST) begin
                    state_d = ST_COAST;
                end else if (cmd == CMD_FWD) begin
                    state_d = ST_DEAD;
                    dcnt_d  = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                // Coast may cut the dead-time short; any drive request waits it out.
                if (cmd == CMD_COAST) begin
                    state_d = ST_COAST;
                    dcnt_d  = '0;
                end else if (dcnt_q == '0) begin
                    state_d = (cmd == CMD_FWD) ? ST_FWD : ST_BWD;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            default: begin
                state_d = ST_COAST;
                dcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COAST;
            dcnt_q    <= '0;
            illegal_q <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            illegal_q <= illegal;
            fault     <= illegal & ~illegal_q;
        end
    end

    always_comb begin
        th_sel = TH0;
        case (duty_sel)
            DSEL_0:  th_sel = TH0;
            DSEL_1:  th_sel = TH1;
            DSEL_2:  th_sel = TH2;
            DSEL_3:  th_sel = TH3;
            default: th_sel = TH0;
        endcase
    end

    // Threshold only moves at the period boundary, so a duty change never
    // truncates or stretches the pulse already in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q <= '0;
        end else if (wrap) begin
            thr_q <= th_sel;
        end
    end

    assign in_fwd = (state_q == ST_FWD);
    assign in_bwd = (state_q == ST_BWD);
    assign en     = (in_fwd | in_bwd) & (cnt < thr_q);

endmodule

// File: rtl/dual_motor_driver.sv
// Two-channel L298-style motor driver: shared PWM period counter, duty
// threshold constants and the combined illegal-command fault pulse.
module dual_motor_driver
    import motor_pkg::*;
#(
    parameter int PERIOD   = 100_000,
    parameter int DEADTIME = 50_000,
    parameter int DUTY0    = 50,
    parameter int DUTY1    = 65,
    parameter int DUTY2    = 80,
    parameter int DUTY3    = 100
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       FWD_A,
    input  logic       BWD_A,
    input  logic       FWD_B,
    input  logic       BWD_B,
    input  logic [1:0] Duty_SelA,
    input  logic [1:0] Duty_SelB,
    output logic       IN1,
    output logic       IN2,
    output logic       IN3,
    output logic       IN4,
    output logic       ENA,
    output logic       ENB,
    output logic       Fault
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TH_W  = $clog2(PERIOD + 1);

    localparam logic [TH_W-1:0] TH0 = TH_W'(PERIOD * DUTY0 / 100);
    localparam logic [TH_W-1:0] TH1 = TH_W'(PERIOD * DUTY1 / 100);
    localparam logic [TH_W-1:0] TH2 = TH_W'(PERIOD * DUTY2 / 100);
    localparam logic [TH_W-1:0] TH3 = TH_W'(PERIOD * DUTY3 / 100);

    logic [CNT_W-1:0] cnt;
    logic [TH_W-1:0]  cnt_ext;
    logic             wrap;
    logic             fault_a;
    logic             fault_b;

    assign wrap    = (cnt == CNT_W'(PERIOD - 1));
    assign cnt_ext = TH_W'(cnt);

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    motor_channel #(
        .TH_W     (TH_W),
        .DEADTIME (DEADTIME),
        .TH0      (TH0),
        .TH1      (TH1),
        .TH2      (TH2),
        .TH3      (TH3)
    ) u_chan_a (
        .clk      (clk),
        .rst      (Reset),
        .fwd      (FWD_A),
        .bwd      (BWD_A),
        .duty_sel (Duty_SelA),
        .cnt      (cnt_ext),
        .wrap     (wrap),
        .in_fwd   (IN1),
        .in_bwd   (IN2),
        .en       (ENA),
        .fault    (fault_a)
    );

    motor_channel #(
        .TH_W     (TH_W),
        .DEADTIME (DEADTIME),
        .TH0      (TH0),
        .TH1      (TH1),
        .TH2      (TH2),
        .TH3      (TH3)
    ) u_chan_b (
        .clk      (clk),
        .rst      (Reset),
        .fwd      (FWD_B),
        .bwd      (BWD_B),
        .duty_sel (Duty_SelB),
        .cnt      (cnt_ext),
        .wrap     (wrap),
        .in_fwd   (IN3),
        .in_bwd   (IN4),
        .en       (ENB),
        .fault    (fault_b)
    );

    assign Fault = fault_a | fault_b;

endmodule

// File: tb/tb_dual_motor_driver.sv
// Directed scoreboard bench for dual_motor_driver with PERIOD=100, DEADTIME=20.
module tb_dual_motor_driver;

    localparam int P  = 100;
    localparam int DT = 20;

    logic       clk = 1'b0;
    logic       Reset;
    logic       FWD_A, BWD_A, FWD_B, BWD_B;
    logic [1:0] Duty_SelA, Duty_SelB;
    logic       IN1, IN2, IN3, IN4, ENA, ENB, Fault;

    always #5 clk = ~clk;

    dual_motor_driver #(
        .PERIOD   (P),
        .DEADTIME (DT)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .FWD_A     (FWD_A),
        .BWD_A     (BWD_A),
        .FWD_B     (FWD_B),
        .BWD_B     (BWD_B),
        .Duty_SelA (Duty_SelA),
        .Duty_SelB (Duty_SelB),
        .IN1       (IN1),
        .IN2       (IN2),
        .IN3       (IN3),
        .IN4       (IN4),
        .ENA       (ENA),
        .ENB       (ENB),
        .Fault     (Fault)
    );

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  phase    = 0;  // expected PWM counter value after the latest edge

    task automatic push(input string tag, input logic [6:0] e);
        sb_t it;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    // Advance one clock, then compare every queued expectation against the pins.
    task automatic tick();
        logic       r;
        logic [6:0] obs;
        sb_t        it;
        r = Reset;
        @(posedge clk);
        #1;
        phase = r ? 0 : ((phase == P - 1) ? 0 : phase + 1);
        obs = {IN1, IN2, IN3, IN4, ENA, ENB, Fault};
        while (sb.size() > 0) begin
            it = sb.pop_front();
            n_assert++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed IN1234/ENA/ENB/Fault=%b required %b (cnt %0d)",
                       it.tag, obs, it.exp, phase);
            end
        end
    endtask

    // Expect fixed direction pins for n cycles, with EN derived from the
    // threshold in force for each channel at the counter value of that cycle.
    task automatic run(input string tag, input int n,
                       input logic i1, input logic i2, input logic i3, input logic i4,
                       input int tha, input int thb, input logic flt);
        for (int k = 0; k < n; k++) begin
            int  q;
            logic ea, eb;
            q  = (phase == P - 1) ? 0 : phase + 1;
            ea = (i1 | i2) && (q < tha);
            eb = (i3 | i4) && (q < thb);
            push(tag, {i1, i2, i3, i4, ea, eb, flt});
            tick();
        end
    endtask

    task automatic run_to(input string tag, input int target,
                          input logic i1, input logic i2, input logic i3, input logic i4,
                          input int tha, input int thb);
        for (int guard = 0; guard < P && phase != target; guard++) begin
            run(tag, 1, i1, i2, i3, i4, tha, thb, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        n_assert++;
        assert (!(IN1 && IN2) && !(IN3 && IN4)) else begin
            n_fail++;
            $error("FAIL bridge_short: observed IN1..IN4=%b%b%b%b required no pair both high",
                   IN1, IN2, IN3, IN4);
        end
    end

    initial begin
        Reset = 1'b1;
        FWD_A = 1'b0; BWD_A = 1'b0; FWD_B = 1'b0; BWD_B = 1'b0;
        Duty_SelA = 2'b00; Duty_SelB = 2'b00;
        push("reset_0", 7'b0);
        tick();
        push("reset_1", 7'b0);
        tick();

        // Forward at 80%: first period has no enable, then 80 high / 20 low.
        Reset = 1'b0;
        FWD_A = 1'b1; Duty_SelA = 2'b10;
        run("fwd_first_period", 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_to("fwd_first_period", P - 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run("fwd_80", P, 1'b1, 1'b0, 1'b0, 1'b0, 80, 50, 1'b0);

        // Duty change mid-period waits for the wrap.
        run_to("sel_pre", 30, 1'b1, 1'b0, 1'b0, 1'b0, 80, 50);
        Duty_SelA = 2'b00;
        run_to("sel_hold80", P - 1, 1'b1, 1'b0, 1'b0, 1'b0, 80, 50);
        run("duty_50", P, 1'b1, 1'b0, 1'b0, 1'b0, 50, 50, 1'b0);

        // Reversal inserts DT coast cycles before backward drive.
        run_to("fwd50", 40, 1'b1, 1'b0, 1'b0, 1'b0, 50, 50);
        FWD_A = 1'b0; BWD_A = 1'b1;
        run("dead_rev", DT, 1'b0, 1'b0, 1'b0, 1'b0, 50, 50, 1'b0);
        run("bwd_pwm", 150, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b0);

        // Coast during dead-time aborts it; a fresh command then has no delay.
        FWD_A = 1'b1; BWD_A = 1'b0;
        run("dead_rev2", 5, 1'b0, 1'b0, 1'b0, 1'b0, 50, 50, 1'b0);
        FWD_A = 1'b0;
        run("dead_abort", 1, 1'b0, 1'b0, 1'b0, 1'b0, 50, 50, 1'b0);
        BWD_A = 1'b1;
        run("coast_to_bwd", 1, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b0);
        run("bwd_again", 30, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b0);

        // Channel B illegal command: one Fault pulse, B coasts, A untouched.
        FWD_B = 1'b1;
        run("b_fwd", 20, 1'b0, 1'b1, 1'b1, 1'b0, 50, 50, 1'b0);
        BWD_B = 1'b1;
        run("b_illegal_first", 1, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b1);
        run("b_illegal_held", 9, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b0);
        FWD_B = 1'b0; BWD_B = 1'b0;
        run("b_release", 3, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b0);
        FWD_B = 1'b1; BWD_B = 1'b1;
        run("b_illegal_again", 1, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b1);
        FWD_B = 1'b0; BWD_B = 1'b0;
        run("b_idle", 2, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50, 1'b0);

        // 100% duty stays high across wraps.
        Duty_SelA = 2'b11;
        run_to("sel11_pre", P - 1, 1'b0, 1'b1, 1'b0, 1'b0, 50, 50);
        run("duty_100", 2 * P, 1'b0, 1'b1, 1'b0, 1'b0, 100, 50, 1'b0);

        // Reset mid-period clears everything; thresholds restart at zero.
        run_to("pre_reset", 37, 1'b0, 1'b1, 1'b0, 1'b0, 100, 50);
        Reset = 1'b1;
        push("reset_mid", 7'b0);
        tick();
        push("reset_hold", 7'b0);
        tick();
        Reset = 1'b0;
        run("post_reset", 30, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
